// File: rtl/fsic_phase_lock_ctrl_if.sv
// Handshake bundle between the io_serdes phase-lock sequencer and its user.
// master drives enable and phase count; slave (the sequencer) returns lock status and strobes.
interface fsic_phase_lock_ctrl_if #(
  parameter int pCLK_RATIO = 4
);
  localparam int PW = $clog2(pCLK_RATIO);

  logic          ctrl_en;
  logic [PW-1:0] phase_cnt_in;
  logic          locked;
  logic          ser_load;
  logic          rx_capture;
  logic [1:0]    state_out;
  logic [7:0]    slip_cnt;

  modport master (
    output ctrl_en, phase_cnt_in,
    input  locked, ser_load, rx_capture, state_out, slip_cnt
  );

  modport slave (
    input  ctrl_en, phase_cnt_in,
    output locked, ser_load, rx_capture, state_out, slip_cnt
  );
endinterface

// File: rtl/fsic_phase_lock_ctrl.sv
// ioclk-domain phase-lock sequencer for io_serdes: locks onto the coreclk phase count and gates load/capture strobes.
// Optional lock-loss counter enabled by defining FSIC_PHASE_SLIP_CNT_EN.
module fsic_phase_lock_ctrl #(
  parameter int pCLK_RATIO  = 4,
  parameter int pLOCK_CNT   = 8,
  parameter int pERR_THRESH = 2,
  parameter int pLOAD_PHASE = 0
) (
  input  logic                   ioclk,
  input  logic                   axis_rst,
  fsic_phase_lock_ctrl_if.slave  pl_if
);
  localparam int PW = $clog2(pCLK_RATIO);
  localparam logic [PW-1:0] LOAD_PH   = PW'(pLOAD_PHASE);
  localparam logic [PW-1:0] CAP_PH    = PW'(pLOAD_PHASE + pCLK_RATIO / 2);
  localparam logic [7:0]    LOCK_LAST = 8'(pLOCK_CNT - 1);
  localparam logic [7:0]    ERR_LAST  = 8'(pERR_THRESH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] exp_phase_q, exp_phase_d;
  logic [PW-1:0] fly_phase_q, fly_phase_d;
  logic [PW-1:0] next_phase, cur_phase;
  logic [7:0]    good_cnt_q, good_cnt_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          ser_load_q, ser_load_d;
  logic          rx_capture_q, rx_capture_d;
  logic          match, strobe_ok;

  always_ff @(posedge ioclk or posedge axis_rst) begin
    if (axis_rst) begin
      state_q      <= IDLE;
      exp_phase_q  <= '0;
      fly_phase_q  <= '0;
      good_cnt_q   <= '0;
      err_cnt_q    <= '0;
      ser_load_q   <= 1'b0;
      rx_capture_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      exp_phase_q  <= exp_phase_d;
      fly_phase_q  <= fly_phase_d;
      good_cnt_q   <= good_cnt_d;
      err_cnt_q    <= err_cnt_d;
      ser_load_q   <= ser_load_d;
      rx_capture_q <= rx_capture_d;
    end
  end

  // In HOLD the flywheel stands in for the untrusted input so the strobe cadence survives a glitch.
  always_comb begin
    next_phase  = pl_if.phase_cnt_in + PW'(1);
    match       = (pl_if.phase_cnt_in == exp_phase_q);
    state_d     = state_q;
    exp_phase_d = next_phase;
    fly_phase_d = fly_phase_q;
    good_cnt_d  = good_cnt_q;
    err_cnt_d   = err_cnt_q;
    cur_phase   = (state_q == LOCKED) ? pl_if.phase_cnt_in : fly_phase_q;

    if (!pl_if.ctrl_en) begin
      state_d     = IDLE;
      good_cnt_d  = '0;
      err_cnt_d   = '0;
      fly_phase_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = ACQUIRE;
          good_cnt_d = '0;
        end
        ACQUIRE: begin
          if (!match) begin
            good_cnt_d = '0;
          end else if (good_cnt_q == LOCK_LAST) begin
            state_d     = LOCKED;
            good_cnt_d  = '0;
            err_cnt_d   = '0;
            fly_phase_d = next_phase;
          end else begin
            good_cnt_d = good_cnt_q + 8'd1;
          end
        end
        LOCKED: begin
          fly_phase_d = next_phase;
          if (!match) begin
            if (pERR_THRESH == 1) begin
              state_d    = ACQUIRE;
              good_cnt_d = '0;
            end else begin
              state_d     = HOLD;
              err_cnt_d   = 8'd1;
              fly_phase_d = fly_phase_q + PW'(1);
            end
          end
        end
        HOLD: begin
          fly_phase_d = fly_phase_q + PW'(1);
          if (match) begin
            state_d   = LOCKED;
            err_cnt_d = '0;
          end else if (err_cnt_q == ERR_LAST) begin
            state_d    = ACQUIRE;
            good_cnt_d = '0;
            err_cnt_d  = '0;
          end else begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      endcase
    end

    // Strobes need lock both now and after this edge, so nothing fires on the way out to ACQUIRE/IDLE.
    strobe_ok    = ((state_q == LOCKED) || (state_q == HOLD)) &&
                   ((state_d == LOCKED) || (state_d == HOLD));
    ser_load_d   = strobe_ok && (cur_phase == LOAD_PH);
    rx_capture_d = strobe_ok && (cur_phase == CAP_PH);
  end

`ifdef FSIC_PHASE_SLIP_CNT_EN
  logic [7:0] slip_cnt_q;
  logic       lose_lock;

  assign lose_lock = ((state_q == LOCKED) || (state_q == HOLD)) && (state_d == ACQUIRE);

  // Lock-loss history survives ctrl_en toggling; only reset clears it.
  always_ff @(posedge ioclk or posedge axis_rst) begin
    if (axis_rst) begin
      slip_cnt_q <= '0;
    end else if (lose_lock && (slip_cnt_q != 8'hFF)) begin
      slip_cnt_q <= slip_cnt_q + 8'd1;
    end
  end

  assign pl_if.slip_cnt = slip_cnt_q;
`else
  assign pl_if.slip_cnt = 8'd0;
`endif

  assign pl_if.state_out  = state_q;
  assign pl_if.locked     = (state_q == LOCKED) || (state_q == HOLD);
  assign pl_if.ser_load   = ser_load_q;
  assign pl_if.rx_capture = rx_capture_q;
endmodule

// File: tb/tb_fsic_phase_lock_ctrl.sv
// Scoreboard bench for fsic_phase_lock_ctrl: directed phase vectors with hand-computed responses.
// Slip count expectations follow FSIC_PHASE_SLIP_CNT_EN.
module tb_fsic_phase_lock_ctrl;
  localparam int N = 52;

  logic ioclk;
  logic axis_rst;

  fsic_phase_lock_ctrl_if #(.pCLK_RATIO(4)) pl_if ();

  fsic_phase_lock_ctrl #(
    .pCLK_RATIO (4),
    .pLOCK_CNT  (8),
    .pERR_THRESH(2),
    .pLOAD_PHASE(0)
  ) dut (
    .ioclk   (ioclk),
    .axis_rst(axis_rst),
    .pl_if   (pl_if)
  );

  initial ioclk = 1'b0;
  always #5 ioclk = ~ioclk;

  typedef struct {
    int idx;
    int st;
    int ser;
    int rx;
    int slip;
  } exp_t;

  exp_t sb_q[$];
  int tests_run = 0;
  int tests_failed = 0;

  // Per vector: ctrl_en, phase in, then the state/ser_load/rx_capture expected one edge later.
  int vec_ctrl [N] = '{1,1,1,1,1,1,1,1,1,1, 1,1,1,1,1,1,1,1,1,1,
                       1,1,1,1,1,1,1,1,1,1, 1,1,1,1,1,1,1,0,0,1,
                       1,1,1,1,1,1,1,1,1,1, 1,1};
  int vec_phase[N] = '{0,1,2,3,0,1,2,3,0,1, 2,3,0,1,2,3,0,3,0,1,
                       2,3,0,3,3,0,1,2,3,0, 1,2,3,0,1,2,3,0,1,2,
                       3,0,1,2,3,0,1,2,3,0, 1,3};
  int vec_st   [N] = '{1,1,1,1,1,1,1,1,2,2, 2,2,2,2,2,2,2,3,2,2,
                       2,2,2,3,1,1,1,1,1,1, 1,1,2,2,2,2,2,0,0,1,
                       1,1,1,1,1,1,1,2,2,2, 2,3};
  int vec_ser  [N] = '{0,0,0,0,0,0,0,0,0,0, 0,0,1,0,0,0,1,0,0,0,
                       0,0,1,0,0,0,0,0,0,0, 0,0,0,1,0,0,0,0,0,0,
                       0,0,0,0,0,0,0,0,0,1, 0,0};
  int vec_rx   [N] = '{0,0,0,0,0,0,0,0,0,0, 1,0,0,0,1,0,0,0,1,0,
                       1,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,1,0,0,0,0,
                       0,0,0,0,0,0,0,0,0,0, 0,0};

  task automatic checkOutput(input string name, input int idx, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s[%0d]: got %0d, expected %0d", name, idx, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag, input int idx);
    checkOutput({tag, "_state"}, idx, int'(pl_if.state_out), 0);
    checkOutput({tag, "_locked"}, idx, int'(pl_if.locked), 0);
    checkOutput({tag, "_ser_load"}, idx, int'(pl_if.ser_load), 0);
    checkOutput({tag, "_rx_capture"}, idx, int'(pl_if.rx_capture), 0);
    checkOutput({tag, "_slip_cnt"}, idx, int'(pl_if.slip_cnt), 0);
  endtask

  task automatic applyStimulus(input int k);
    exp_t e;
    pl_if.ctrl_en      = vec_ctrl[k][0];
    pl_if.phase_cnt_in = 2'(vec_phase[k]);
    e.idx = k;
    e.st  = vec_st[k];
    e.ser = vec_ser[k];
    e.rx  = vec_rx[k];
`ifdef FSIC_PHASE_SLIP_CNT_EN
    e.slip = (k >= 24) ? 1 : 0;
`else
    e.slip = 0;
`endif
    sb_q.push_back(e);
    @(negedge ioclk);
  endtask

  // Monitor: every output update is checked against the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge ioclk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checkOutput("state_out", e.idx, int'(pl_if.state_out), e.st);
        checkOutput("locked", e.idx, int'(pl_if.locked), (e.st >= 2) ? 1 : 0);
        checkOutput("ser_load", e.idx, int'(pl_if.ser_load), e.ser);
        checkOutput("rx_capture", e.idx, int'(pl_if.rx_capture), e.rx);
        checkOutput("slip_cnt", e.idx, int'(pl_if.slip_cnt), e.slip);
      end
    end
  end

  initial begin
    int guard;
    axis_rst           = 1'b1;
    pl_if.ctrl_en      = 1'b1;
    pl_if.phase_cnt_in = 2'd0;

    for (int i = 0; i < 4; i++) begin
      @(negedge ioclk);
      pl_if.phase_cnt_in = pl_if.phase_cnt_in + 2'd1;
      #1;
      checkAllZero("rst_hold", i);
    end

    @(negedge ioclk);
    axis_rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      applyStimulus(k);
    end

    guard = 0;
    while ((sb_q.size() != 0) && (guard < 10)) begin
      @(negedge ioclk);
      guard++;
    end
    checkOutput("sb_drain", 0, sb_q.size(), 0);

    // DUT sits in HOLD here; reset must clear outputs without waiting for an edge.
    #2;
    axis_rst = 1'b1;
    #1;
    checkAllZero("rst_async", 0);
    @(negedge ioclk);
    checkAllZero("rst_async", 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/fsic_phase_lock_ctrl.md
Name: fsic_phase_lock_ctrl

Overview:
- ioclk-domain sequencer for the io_serdes serializer/deserializer.
- Monitors the core-clock phase count from the phase counter and checks that it advances by +1 mod pCLK_RATIO every ioclk.
- Declares lock after a run of consistent phases and gates serializer load and deserializer capture strobes on lock.
- Flywheels through short phase glitches (HOLD) and drops to re-acquire after pERR_THRESH consecutive errors.

Parameters:
- pCLK_RATIO, 4: ioclk/coreclk ratio; power of 2, at least 2. PW = $clog2(pCLK_RATIO).
- pLOCK_CNT, 8: consecutive good phases required to lock; range 1..255.
- pERR_THRESH, 2: consecutive mismatches that drop lock; range 1..255.
- pLOAD_PHASE, 0: phase at which ser_load pulses; range 0..pCLK_RATIO-1.

Ports:
- ioclk  in  1  io clock; the only clock.
- axis_rst  in  1  asynchronous, active-high reset.
- ctrl_en  in  1  enable; 0 forces IDLE.
- phase_cnt_in  in  PW  phase count from the phase counter, ioclk domain.
- locked  out  1  1 in LOCKED or HOLD.
- ser_load  out  1  1-cycle serializer load strobe.
- rx_capture  out  1  1-cycle deserializer capture strobe.
- state_out  out  2  encoding: IDLE=0, ACQUIRE=1, LOCKED=2, HOLD=3.
- slip_cnt  out  8  lock-loss count (optional feature).

Behaviour:
- Reset (async assert, release synchronous to ioclk):
  - state = IDLE; all outputs 0; exp_phase = 0; good_cnt = 0; err_cnt = 0; fly_phase = 0.
- Every cycle, regardless of state: exp_phase <= (phase_cnt_in + 1) mod pCLK_RATIO.
- match = (phase_cnt_in == exp_phase). Wrap from pCLK_RATIO-1 to 0 is a match.
- ctrl_en = 0 in any state:
  - next state IDLE; good_cnt, err_cnt, fly_phase cleared.
  - ctrl_en has priority over every other transition.
- IDLE: ctrl_en = 1 -> ACQUIRE, good_cnt = 0.
- ACQUIRE:
  - match -> good_cnt + 1; mismatch -> good_cnt = 0.
  - match while good_cnt == pLOCK_CNT-1 -> LOCKED; err_cnt = 0; fly_phase <= (phase_cnt_in + 1) mod R.
  - Net effect: lock after exactly pLOCK_CNT consecutive matches.
- LOCKED:
  - fly_phase <= (phase_cnt_in + 1) mod R.
  - match -> stay.
  - mismatch and pERR_THRESH == 1 -> ACQUIRE (lock loss).
  - mismatch otherwise -> HOLD, err_cnt = 1, fly_phase <= fly_phase + 1 (the input is ignored).
- HOLD:
  - fly_phase <= fly_phase + 1 mod R.
  - match -> LOCKED, err_cnt = 0.
  - mismatch and err_cnt + 1 == pERR_THRESH -> ACQUIRE, good_cnt = 0 (lock loss).
  - mismatch otherwise -> err_cnt + 1.
- Strobe phase: cur_phase = phase_cnt_in in LOCKED; cur_phase = fly_phase in HOLD.
- All outputs registered, 1-cycle latency from the phase_cnt_in sample:
  - ser_load <= (state in {LOCKED, HOLD}) && (cur_phase == pLOAD_PHASE).
  - rx_capture <= same gating && (cur_phase == (pLOAD_PHASE + pCLK_RATIO/2) mod R).
  - locked and state_out reflect the registered state.
- Counters never exceed their thresholds. No strobe is issued in the cycle the FSM enters ACQUIRE or IDLE.
- Counter widths are 8 bits.

Optional Feature:
- Macro FSIC_PHASE_SLIP_CNT_EN.
- Defined:
  - slip_cnt increments on each lock-loss transition (LOCKED->ACQUIRE or HOLD->ACQUIRE).
  - Saturates at 255.
  - Cleared by reset only; ctrl_en has no effect on it.
- Undefined: slip_cnt tied to 0; no counter register.

Test Plan (R=4, pLOCK_CNT=8, pERR_THRESH=2, pLOAD_PHASE=0):
- Reset held, phase stream running -> all outputs 0, state_out=0. Release with ctrl_en=1 -> state_out=1 next cycle.
- Clean phase stream 0,1,2,3,... -> locked=1 after the 8th consecutive match. ser_load pulses once per 4 cycles, one cycle after phase 0 is sampled. rx_capture follows phase 2.
- While LOCKED, replace one phase with a wrong value -> state_out=3 for that cycle, locked stays 1, ser_load cadence unchanged (flywheel). Stream resumes -> state_out=2.
- Two consecutive wrong phases -> state ACQUIRE, locked=0, strobes stop. slip_cnt=1 with FSIC_PHASE_SLIP_CNT_EN, 0 without. Relock after 8 good phases.
- Deassert ctrl_en mid-LOCKED -> state_out=0 and strobes 0 next cycle. Reassert -> full 8-match reacquire required.
- Assert axis_rst mid-HOLD -> all outputs 0 immediately (asynchronous); slip_cnt cleared.
